// File: rtl/irq_source_controller.sv
// -----------------------------------------------------------------------------
// irq_source_controller
//
// Requester side of the core interrupt handshake. External interrupt lines are
// captured into a pending register (edge or level per source). The lowest
// indexed unmasked pending source is requested from the core. After a request
// the controller waits for irq_grant_i, then for irq_done_i, before it issues
// the next request. core_flush_i aborts the handshake from any state.
//
// Ports
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   enable_i       core enabled; gates new requests from IDLE
//   irq_src_i      interrupt lines (synchronous to clk)
//   irq_mask_i     1 = source may be requested
//   irq_req_o      request to the core
//   irq_addr_o     handler address of the requested source
//   irq_id_o       index of the source being requested / serviced
//   irq_grant_i    core entered the handler
//   irq_done_i     core returned from the handler
//   core_flush_i   core flush; returns the controller to IDLE
//   irq_pending_o  pending register (masked and unmasked)
//   irq_busy_o     controller is not IDLE
//   irq_timeout_o  sticky: a request waited TIMEOUT cycles for its grant
// -----------------------------------------------------------------------------
module irq_source_controller #(
    parameter int          NUM_SRC    = 8,
    parameter logic [31:0] EDGE_MASK  = 32'h0000_00FF,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0100,
    parameter logic [31:0] VEC_STRIDE = 32'd4,
    parameter logic [15:0] TIMEOUT    = 16'd1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable_i,
    input  logic [NUM_SRC-1:0] irq_src_i,
    input  logic [NUM_SRC-1:0] irq_mask_i,
    output logic               irq_req_o,
    output logic [31:0]        irq_addr_o,
    output logic [4:0]         irq_id_o,
    input  logic               irq_grant_i,
    input  logic               irq_done_i,
    input  logic               core_flush_i,
    output logic [NUM_SRC-1:0] irq_pending_o,
    output logic               irq_busy_o,
    output logic               irq_timeout_o
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        REQUEST    = 2'd1,
        IN_SERVICE = 2'd2
    } state_t;

    localparam logic [NUM_SRC-1:0] EDGE_SEL = EDGE_MASK[NUM_SRC-1:0];

    state_t               state_q, state_d;
    logic [NUM_SRC-1:0]   src_q;
    logic [NUM_SRC-1:0]   pending_q;
    logic [NUM_SRC-1:0]   cand;
    logic [NUM_SRC-1:0]   set_vec;
    logic [NUM_SRC-1:0]   clr_vec;
    logic [4:0]           sel_id;
    logic                 sel_valid;
    logic                 take;
    logic                 grant_acc;
    logic [4:0]           id_q;
    logic [31:0]          addr_q;
    logic [15:0]          cnt_q;
    logic                 timeout_q;

    function automatic logic [31:0] vec_addr(input logic [4:0] id);
        return BASE_ADDR + (32'(id) * VEC_STRIDE);
    endfunction

    // Edge sources need a low-to-high transition; level sources set while high.
    assign set_vec = (EDGE_SEL & irq_src_i & ~src_q) | (~EDGE_SEL & irq_src_i);
    assign cand    = pending_q & irq_mask_i;

    // Lowest index wins: scan downwards so the last hit is the smallest index.
    always_comb begin
        sel_id    = '0;
        sel_valid = |cand;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (cand[i]) sel_id = 5'(i);
        end
    end

    // Next-state logic; flush overrides every other transition.
    always_comb begin
        state_d   = state_q;
        take      = 1'b0;
        grant_acc = 1'b0;
        if (core_flush_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable_i && sel_valid) begin
                        state_d = REQUEST;
                        take    = 1'b1;
                    end
                end
                REQUEST: begin
                    if (irq_grant_i) begin
                        state_d   = IN_SERVICE;
                        grant_acc = 1'b1;
                    end
                end
                IN_SERVICE: begin
                    if (irq_done_i) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Only an accepted grant clears the serviced bit; a flush leaves it pending.
    always_comb begin
        clr_vec = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            clr_vec[i] = grant_acc && (id_q == 5'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Set has priority over clear-on-grant for the same bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q     <= '0;
            pending_q <= '0;
        end else begin
            src_q     <= irq_src_i;
            pending_q <= (pending_q & ~clr_vec) | set_vec;
        end
    end

    // id/addr are captured once on entry to REQUEST and held afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_q   <= '0;
            addr_q <= '0;
        end else if (take) begin
            id_q   <= sel_id;
            addr_q <= vec_addr(sel_id);
        end
    end

    // Grant-wait counter: saturates at TIMEOUT, flag is sticky until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else if (take) begin
            cnt_q <= '0;
        end else if (state_q == REQUEST && TIMEOUT != 16'd0 && cnt_q != TIMEOUT) begin
            cnt_q <= cnt_q + 16'd1;
            if (cnt_q + 16'd1 == TIMEOUT) timeout_q <= 1'b1;
        end
    end

    assign irq_req_o     = (state_q == REQUEST);
    assign irq_busy_o    = (state_q != IDLE);
    assign irq_id_o      = id_q;
    assign irq_addr_o    = addr_q;
    assign irq_pending_o = pending_q;
    assign irq_timeout_o = timeout_q;

endmodule

// File: tb/tb_irq_source_controller.sv
// -----------------------------------------------------------------------------
// tb_irq_source_controller
//
// Directed bench for irq_source_controller: a table of per-cycle vectors for
// the basic handshake and priority ordering, plus hand-written sequences for
// level/mask, flush, timeout and asynchronous reset.
// Source 1 is level triggered, all other sources are edge triggered.
// -----------------------------------------------------------------------------
module tb_irq_source_controller;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [7:0]  src;
    logic [7:0]  mask;
    logic        req;
    logic [31:0] addr;
    logic [4:0]  id;
    logic        grant;
    logic        done;
    logic        flush;
    logic [7:0]  pending;
    logic        busy;
    logic        timeout;

    int n_vec;
    int n_err;

    irq_source_controller #(
        .NUM_SRC    (8),
        .EDGE_MASK  (32'h0000_00FD),
        .BASE_ADDR  (32'h0000_0100),
        .VEC_STRIDE (32'd4),
        .TIMEOUT    (16'd16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable_i      (enable),
        .irq_src_i     (src),
        .irq_mask_i    (mask),
        .irq_req_o     (req),
        .irq_addr_o    (addr),
        .irq_id_o      (id),
        .irq_grant_i   (grant),
        .irq_done_i    (done),
        .core_flush_i  (flush),
        .irq_pending_o (pending),
        .irq_busy_o    (busy),
        .irq_timeout_o (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  src;
        logic [7:0]  mask;
        logic        en;
        logic        grant;
        logic        done;
        logic        flush;
        logic        req;
        logic        busy;
        logic [4:0]  id;
        logic [31:0] addr;
        logic [7:0]  pend;
    } vec_t;

    vec_t tbl[$];

    task automatic vec(input logic [7:0] s, input logic [7:0] m, input logic e,
                       input logic g, input logic d, input logic f,
                       input logic r, input logic b, input logic [4:0] i,
                       input logic [31:0] a, input logic [7:0] p);
        vec_t v;
        v.src = s; v.mask = m; v.en = e; v.grant = g; v.done = d; v.flush = f;
        v.req = r; v.busy = b; v.id = i; v.addr = a; v.pend = p;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive happens 1 time unit after a rising edge; this advances one edge
    // and leaves time at edge+1 for sampling.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] s, input logic g, input logic d, input logic f);
        src = s; grant = g; done = d; flush = f;
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        rst_n  = 1'b0;
        enable = 1'b1;
        src    = '0;
        mask   = 8'hFF;
        grant  = 1'b0;
        done   = 1'b0;
        flush  = 1'b0;

        // ---------------- reset state ----------------
        cyc();
        cyc();
        chk("rst.req", req, 0);
        chk("rst.busy", busy, 0);
        chk("rst.pend", pending, 0);
        chk("rst.id", id, 0);
        chk("rst.addr", addr, 0);
        chk("rst.timeout", timeout, 0);
        rst_n = 1'b1;

        // ---------------- table: single edge, priority, enable gating -----
        //   src    mask  en g  d  f   req busy id  addr          pend
        vec(8'h08, 8'hFF, 1, 0, 0, 0,  0,  0,  0, 32'h0000_0000, 8'h08);
        vec(8'h00, 8'hFF, 1, 0, 0, 0,  1,  1,  3, 32'h0000_010C, 8'h08);
        vec(8'h00, 8'hFF, 1, 0, 1, 0,  1,  1,  3, 32'h0000_010C, 8'h08); // done ignored in REQUEST
        vec(8'h00, 8'hFF, 1, 1, 0, 0,  0,  1,  3, 32'h0000_010C, 8'h00);
        vec(8'h00, 8'hFF, 1, 0, 1, 0,  0,  0,  3, 32'h0000_010C, 8'h00);
        vec(8'h00, 8'hFF, 1, 0, 0, 0,  0,  0,  3, 32'h0000_010C, 8'h00);
        vec(8'h24, 8'hFF, 1, 0, 0, 0,  0,  0,  3, 32'h0000_010C, 8'h24);
        vec(8'h00, 8'hFF, 1, 0, 0, 0,  1,  1,  2, 32'h0000_0108, 8'h24);
        vec(8'h00, 8'hFF, 1, 1, 0, 0,  0,  1,  2, 32'h0000_0108, 8'h20);
        vec(8'h00, 8'hFF, 1, 0, 1, 0,  0,  0,  2, 32'h0000_0108, 8'h20);
        vec(8'h00, 8'hFF, 1, 0, 0, 0,  1,  1,  5, 32'h0000_0114, 8'h20);
        vec(8'h00, 8'hFF, 1, 1, 0, 0,  0,  1,  5, 32'h0000_0114, 8'h00);
        vec(8'h00, 8'hFF, 1, 0, 1, 0,  0,  0,  5, 32'h0000_0114, 8'h00);
        vec(8'h00, 8'hFF, 1, 1, 0, 0,  0,  0,  5, 32'h0000_0114, 8'h00); // grant ignored in IDLE
        vec(8'h01, 8'hFF, 0, 0, 0, 0,  0,  0,  5, 32'h0000_0114, 8'h01);
        vec(8'h00, 8'hFF, 0, 0, 0, 0,  0,  0,  5, 32'h0000_0114, 8'h01); // enable low blocks
        vec(8'h00, 8'hFF, 1, 0, 0, 0,  1,  1,  0, 32'h0000_0100, 8'h01);
        vec(8'h00, 8'hFF, 1, 1, 0, 0,  0,  1,  0, 32'h0000_0100, 8'h00);
        vec(8'h00, 8'hFF, 1, 0, 1, 0,  0,  0,  0, 32'h0000_0100, 8'h00);

        foreach (tbl[i]) begin
            src = tbl[i].src; mask = tbl[i].mask; enable = tbl[i].en;
            grant = tbl[i].grant; done = tbl[i].done; flush = tbl[i].flush;
            cyc();
            chk($sformatf("v%0d.req", i), req, tbl[i].req);
            chk($sformatf("v%0d.busy", i), busy, tbl[i].busy);
            chk($sformatf("v%0d.id", i), id, tbl[i].id);
            chk($sformatf("v%0d.addr", i), addr, tbl[i].addr);
            chk($sformatf("v%0d.pend", i), pending, tbl[i].pend);
        end
        drive(8'h00, 0, 0, 0);
        enable = 1'b1;

        // ---------------- level source with mask ----------------
        mask = 8'hFD;
        drive(8'h02, 0, 0, 0);
        cyc();
        chk("lvl.pend_masked", pending, 8'h02);
        cyc();
        chk("lvl.no_req", req, 0);
        chk("lvl.pend_hold", pending, 8'h02);
        mask = 8'hFF;
        cyc();
        chk("lvl.req", req, 1);
        chk("lvl.id", id, 1);
        chk("lvl.addr", addr, 32'h0000_0104);
        drive(8'h02, 1, 0, 0);
        cyc();
        chk("lvl.grant_req", req, 0);
        chk("lvl.set_wins", pending, 8'h02);
        drive(8'h02, 0, 1, 0);
        cyc();
        chk("lvl.done_busy", busy, 0);
        drive(8'h02, 0, 0, 0);
        cyc();
        chk("lvl.rereq", req, 1);
        chk("lvl.rereq_id", id, 1);
        drive(8'h00, 1, 0, 0);
        cyc();
        chk("lvl.clear", pending, 8'h00);
        drive(8'h00, 0, 1, 0);
        cyc();
        chk("lvl.idle", busy, 0);
        drive(8'h00, 0, 0, 0);

        // ---------------- flush ----------------
        drive(8'h10, 0, 0, 0);
        cyc();
        drive(8'h00, 0, 0, 0);
        cyc();
        chk("fl.req", req, 1);
        chk("fl.id", id, 4);
        drive(8'h00, 0, 0, 1);
        cyc();
        chk("fl.req_drop", req, 0);
        chk("fl.busy", busy, 0);
        chk("fl.pend_kept", pending, 8'h10);
        drive(8'h00, 0, 0, 0);
        cyc();
        chk("fl.rereq", req, 1);
        chk("fl.rereq_addr", addr, 32'h0000_0110);
        drive(8'h00, 1, 0, 0);
        cyc();
        chk("fl.grant_pend", pending, 8'h00);
        drive(8'h00, 0, 0, 1);
        cyc();
        chk("fl.svc_busy", busy, 0);
        drive(8'h00, 0, 0, 0);
        cyc();
        cyc();
        cyc();
        chk("fl.no_rereq", req, 0);
        chk("fl.no_pend", pending, 8'h00);
        chk("fl.timeout_clear", timeout, 0);

        // ---------------- timeout ----------------
        drive(8'h80, 0, 0, 0);
        cyc();
        drive(8'h00, 0, 0, 0);
        cyc();
        chk("to.req", req, 1);
        chk("to.addr", addr, 32'h0000_011C);
        for (int k = 0; k < 15; k++) cyc();
        chk("to.before", timeout, 0);
        cyc();
        chk("to.at16", timeout, 1);
        chk("to.still_req", req, 1);
        cyc();
        cyc();
        drive(8'h00, 1, 0, 0);
        cyc();
        chk("to.grant", req, 0);
        chk("to.grant_pend", pending, 8'h00);
        drive(8'h00, 0, 1, 0);
        cyc();
        chk("to.done_busy", busy, 0);
        chk("to.sticky", timeout, 1);
        drive(8'h00, 0, 0, 0);

        // ---------------- asynchronous reset mid-REQUEST ----------------
        drive(8'h40, 0, 0, 0);
        cyc();
        drive(8'h00, 0, 0, 0);
        cyc();
        chk("ar.req", req, 1);
        chk("ar.id", id, 6);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar.req0", req, 0);
        chk("ar.pend0", pending, 8'h00);
        chk("ar.busy0", busy, 0);
        chk("ar.timeout0", timeout, 0);
        chk("ar.addr0", addr, 0);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("ar.stay_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
